// File: rtl/pipe_skid_stage_pkg.sv
// ---------------------------------------------------------------------------
// Shared definitions for the pipeline skid stage.
//
// cpu_pipe_pkg
//     Field layout of the MEM/WB payload. The stage that instantiates
//     pipe_skid_stage concatenates its fields using these offsets. The same
//     constants size the stage's payload and build its kill mask.
//
// pipe_skid_stage_pkg
//     Occupancy encoding of the two-entry skid stage, and a helper that
//     classifies a (main_v, skid_v) pair.
//
// Ports: none (packages only).
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

    // MEM/WB field widths.
    localparam int MEMWB_REGWRITE_W  = 1;
    localparam int MEMWB_RESULTSRC_W = 2;
    localparam int MEMWB_READDATA_W  = 32;
    localparam int MEMWB_ALURES_W    = 32;
    localparam int MEMWB_PCPLUS4_W   = 32;
    localparam int MEMWB_RD_W        = 5;

    // MEM/WB field offsets, LSB first.
    localparam int REGWRITE_BIT  = 0;
    localparam int RESULTSRC_LSB = 1;
    localparam int READDATA_LSB  = 3;
    localparam int ALURES_LSB    = 35;
    localparam int PCPLUS4_LSB   = 67;
    localparam int RD_LSB        = 99;

    // The fields use 104 bits. Four spare bits are kept at the top so that
    // the bundle can grow without resizing every stage register.
    localparam int MEMWB_USED_W    = RD_LSB + MEMWB_RD_W;
    localparam int MEMWB_SPARE_W   = 4;
    localparam int MEMWB_PAYLOAD_W = MEMWB_USED_W + MEMWB_SPARE_W;

    // Only RegWrite has to be forced low for a bubble. MemWrite has already
    // been consumed by the time a payload reaches MEM/WB.
    localparam logic [MEMWB_PAYLOAD_W-1:0] MEMWB_KILL_MASK =
        MEMWB_PAYLOAD_W'(1) << REGWRITE_BIT;

endpackage

package pipe_skid_stage_pkg;

    // How many entries the stage holds. OCC_ILLEGAL is a skid entry with no
    // main entry, which the update rules can never produce.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_ONE     = 2'b01,
        OCC_FULL    = 2'b10,
        OCC_ILLEGAL = 2'b11
    } occ_e;

    function automatic occ_e occupancy(input logic mainV, input logic skidV);
        occ_e occ;
        case ({mainV, skidV})
            2'b00:   occ = OCC_EMPTY;
            2'b10:   occ = OCC_ONE;
            2'b11:   occ = OCC_FULL;
            default: occ = OCC_ILLEGAL;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// ---------------------------------------------------------------------------
// Handshake bundle for pipe_skid_stage. The bundle holds both the upstream
// side (in_*) and the downstream side (out_*), so one connection carries the
// full boundary.
//
//   in_valid   upstream has a payload
//   in_ready   stage can accept (driven by the stage)
//   in_data    upstream payload
//   out_valid  stage holds a live payload (driven by the stage)
//   out_ready  downstream accepts this cycle
//   out_data   payload to the next stage (driven by the stage)
//
// Modports:
//   slave   the stage itself
//   master  the surrounding logic, which drives in_* and out_ready
// ---------------------------------------------------------------------------
interface pipe_skid_stage_if
    import cpu_pipe_pkg::*;
#(
    parameter int PAYLOAD_W = MEMWB_PAYLOAD_W
);

    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pipe_skid_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg: one valid+data register slot of the skid stage.
//
//   clk      rising-edge clock
//   reset    synchronous, active-high; valid=0, data=RESET_VAL
//   i_clear  drop the entry (valid=0); the data bits keep their value
//   i_load   capture i_data and mark the entry valid
//   i_data   value to capture
//   o_valid  entry is live
//   o_data   stored value
//
// The priority is reset, then clear, then load. A flush is a clear, so a
// load requested in the same cycle as a flush is discarded.
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int             W         = MEMWB_PAYLOAD_W,
    parameter logic [W-1:0]   RESET_VAL = '0
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // A clear leaves the data bits untouched. Only the valid bit matters
    // after a clear, and holding the data avoids toggling a wide bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage: a generic pipeline-boundary register with a valid/ready
// handshake and a two-entry skid buffer.
//
// The main entry drives the outputs. The skid entry catches the one payload
// that can arrive in the cycle when the downstream stalls. Because in_ready
// comes only from the skid valid flag, there is no combinational path from
// out_ready to in_ready.
//
// Whenever the stage holds a bubble, the bits set in KILL_MASK read 0 on
// out_data. A squashed instruction therefore can never assert its commit
// controls.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; takes priority over flush
//   flush   synchronous squash of both entries; takes priority over transfers
//   bus     pipe_skid_stage_if.slave (in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data)
//
// Optional build macro PIPE_SKID_STATS_EN adds two outputs:
//   stall_cnt   cycles with out_valid & ~out_ready
//   bubble_cnt  non-reset cycles with ~out_valid
// Both counters wrap at 2^32. Reset clears them and flush does not.
// ---------------------------------------------------------------------------
module pipe_skid_stage
    import cpu_pipe_pkg::*;
    import pipe_skid_stage_pkg::*;
#(
    parameter int                   PAYLOAD_W = MEMWB_PAYLOAD_W,
    parameter logic [PAYLOAD_W-1:0] KILL_MASK = '0,
    parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_skid_stage_if.slave  bus
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    logic                 w_main_v;
    logic [PAYLOAD_W-1:0] w_main_d;
    logic                 w_skid_v;
    logic [PAYLOAD_W-1:0] w_skid_d;

    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_out_fire;

    logic                 w_main_load;
    logic                 w_main_clear;
    logic [PAYLOAD_W-1:0] w_main_next;
    logic                 w_skid_load;
    logic                 w_skid_clear;

    occ_e                 w_occ;

    assign w_in_ready = ~w_skid_v;
    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_main_v & bus.out_ready;

    // Control for the two entries.
    //
    // The main entry loads in two cases. First, when it is empty and a new
    // payload arrives. Second, when it is draining and a replacement is
    // available. The skid entry is the older payload, so it has priority.
    // The two sources never compete, because a valid skid entry holds
    // in_ready low.
    //
    // The skid entry fills only when the main entry is stuck and a payload
    // still arrives. That payload was accepted on the previous cycle's
    // in_ready. A flush suppresses every load and clears both entries.
    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_next  = w_skid_v ? w_skid_d : bus.in_data;

        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (!w_main_v) begin
            w_main_load = w_in_fire;
        end else if (w_out_fire) begin
            if (w_skid_v) begin
                w_main_load  = 1'b1;
                w_skid_clear = 1'b1;
            end else if (w_in_fire) begin
                w_main_load  = 1'b1;
            end else begin
                w_main_clear = 1'b1;
            end
        end else begin
            w_skid_load = w_in_fire;
        end
    end

    pipe_skid_reg #(
        .W         (PAYLOAD_W),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_data  (w_main_next),
        .o_valid (w_main_v),
        .o_data  (w_main_d)
    );

    pipe_skid_reg #(
        .W         (PAYLOAD_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_data  (bus.in_data),
        .o_valid (w_skid_v),
        .o_data  (w_skid_d)
    );

    // When the main entry is a bubble, its stale data is still shown
    // downstream with the kill bits forced low. Every commit control the
    // next stage sees is then inactive.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_main_v;
    assign bus.out_data  = w_main_v ? w_main_d : (w_main_d & ~KILL_MASK);

    // A skid entry behind an empty main entry would leave the FIFO order
    // undefined. The update rules cannot reach that state.
    assign w_occ = occupancy(w_main_v, w_skid_v);

    a_no_orphan_skid : assert property (
        @(posedge clk) disable iff (reset) w_occ != OCC_ILLEGAL
    );

`ifdef PIPE_SKID_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Performance counters. Stalls count held payloads and bubbles count
    // idle cycles. Both wrap naturally. Flush leaves them alone, so the
    // counts stay meaningful across branch mispredicts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_main_v && !bus.out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!w_main_v) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_skid_stage, built with the MEM/WB layout and kill mask.
// The table holds one record per clock. Each record gives the inputs driven
// before the edge and the outputs required just after it. Hand-written
// sequences cover reset in mid-flow and the optional statistics counters.
// Build with PIPE_SKID_STATS_EN defined to include the counter checks.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;
    import cpu_pipe_pkg::*;

    localparam int W = MEMWB_PAYLOAD_W;

    logic clk;
    logic reset;
    logic flush;

    pipe_skid_stage_if #(.PAYLOAD_W(W)) bus ();

`ifdef PIPE_SKID_STATS_EN
    logic [31:0] stallCnt;
    logic [31:0] bubbleCnt;
`endif

    pipe_skid_stage #(
        .PAYLOAD_W (W),
        .KILL_MASK (MEMWB_KILL_MASK),
        .RESET_VAL ('0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .bus        (bus.slave)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt  (stallCnt),
        .bubble_cnt (bubbleCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         fl;
        logic         inValid;
        logic [W-1:0] inData;
        logic         outReady;
        logic         expOutValid;
        logic         expInReady;
        logic [W-1:0] expOutData;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [W-1:0] WIDE = 108'hABC_DEF01234_56789ABC_DEF01235;

    task automatic addVec(input logic rst, input logic fl, input logic iv,
                          input logic [W-1:0] d, input logic ordy,
                          input logic eov, input logic eir,
                          input logic [W-1:0] eod);
        vec_t v;
        v.rst = rst; v.fl = fl; v.inValid = iv; v.inData = d;
        v.outReady = ordy; v.expOutValid = eov; v.expInReady = eir;
        v.expOutData = eod;
        vecs.push_back(v);
    endtask

    // Drive the inputs on the falling edge, then let one rising edge pass.
    // The outputs are sampled 1 time unit after that edge.
    task automatic applyStimulus(input logic rst, input logic fl,
                                 input logic iv, input logic [W-1:0] d,
                                 input logic ordy);
        @(negedge clk);
        reset         = rst;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset for two cycles with in_valid high.
        addVec(1, 0, 1, W'(8'h99), 0, 0, 1, '0);
        addVec(1, 0, 1, W'(8'h99), 0, 0, 1, '0);
        // Streaming: each push appears one cycle later, with no bubbles.
        for (int k = 0; k < 8; k++)
            addVec(0, 0, 1, W'(8'h11 + k), 1, 1, 1, W'(8'h11 + k));
        addVec(0, 0, 0, '0, 1, 0, 1, W'(8'h18));
        addVec(0, 0, 1, WIDE, 1, 1, 1, WIDE);
        addVec(0, 0, 0, '0, 1, 0, 1, WIDE & ~W'(1));
        // Backpressure: A, then B into skid; C is ignored while full.
        addVec(0, 0, 1, W'(8'h21), 0, 1, 1, W'(8'h21));
        addVec(0, 0, 1, W'(8'h22), 0, 1, 0, W'(8'h21));
        addVec(0, 0, 1, W'(8'h23), 0, 1, 0, W'(8'h21));
        addVec(0, 0, 0, '0, 1, 1, 1, W'(8'h22));
        addVec(0, 0, 0, '0, 1, 0, 1, W'(8'h22));
        // Skid drains first, then a new payload follows at full rate.
        addVec(0, 0, 1, W'(8'h61), 0, 1, 1, W'(8'h61));
        addVec(0, 0, 1, W'(8'h62), 0, 1, 0, W'(8'h61));
        addVec(0, 0, 1, W'(8'h63), 1, 1, 1, W'(8'h62));
        addVec(0, 0, 1, W'(8'h63), 1, 1, 1, W'(8'h63));
        addVec(0, 0, 0, '0, 1, 0, 1, W'(8'h62));
        // Flush while full with C offered: C is never emitted, RegWrite reads 0.
        addVec(0, 0, 1, W'(8'h31), 0, 1, 1, W'(8'h31));
        addVec(0, 0, 1, W'(8'h33), 0, 1, 0, W'(8'h31));
        addVec(0, 1, 1, W'(8'h35), 0, 0, 1, W'(8'h30));
        addVec(0, 0, 0, '0, 1, 0, 1, W'(8'h30));
        // Flush while empty discards an in_fire.
        addVec(0, 1, 1, W'(8'h41), 1, 0, 1, W'(8'h30));
        addVec(0, 0, 0, '0, 1, 0, 1, W'(8'h30));
        // Flush together with out_fire still clears the entry.
        addVec(0, 0, 1, W'(8'h51), 0, 1, 1, W'(8'h51));
        addVec(0, 1, 0, '0, 1, 0, 1, W'(8'h50));
        // Reset beats flush and load.
        addVec(1, 1, 1, W'(8'h71), 1, 0, 1, '0);
        addVec(0, 0, 0, '0, 1, 0, 1, '0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].inValid,
                          vecs[i].inData, vecs[i].outReady);
            checkOutput($sformatf("v%0d.out_valid", i), W'(bus.out_valid), W'(vecs[i].expOutValid));
            checkOutput($sformatf("v%0d.in_ready", i), W'(bus.in_ready), W'(vecs[i].expInReady));
            checkOutput($sformatf("v%0d.out_data", i), bus.out_data, vecs[i].expOutData);
        end

        // Reset while full and stalled; nothing stale comes out afterwards.
        applyStimulus(0, 0, 1, W'(8'h81), 0);
        applyStimulus(0, 0, 1, W'(8'h83), 0);
        checkOutput("mid.full_in_ready", W'(bus.in_ready), W'(0));
        applyStimulus(1, 0, 1, W'(8'h85), 0);
        checkOutput("mid.rst_out_valid", W'(bus.out_valid), W'(0));
        checkOutput("mid.rst_in_ready", W'(bus.in_ready), W'(1));
        checkOutput("mid.rst_out_data", bus.out_data, '0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, '0, 1);
            checkOutput($sformatf("mid.post%0d_out_valid", k), W'(bus.out_valid), W'(0));
            checkOutput($sformatf("mid.post%0d_out_data", k), bus.out_data, '0);
        end

`ifdef PIPE_SKID_STATS_EN
        applyStimulus(1, 0, 0, '0, 0);
        checkOutput("stats.rst_stall", W'(stallCnt), W'(0));
        checkOutput("stats.rst_bubble", W'(bubbleCnt), W'(0));
        applyStimulus(0, 0, 1, W'(8'h91), 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, '0, 0);
        applyStimulus(0, 0, 0, '0, 1);
        for (int k = 0; k < 2; k++) applyStimulus(0, 0, 0, '0, 1);
        checkOutput("stats.stall", W'(stallCnt), W'(3));
        checkOutput("stats.bubble", W'(bubbleCnt), W'(3));
        applyStimulus(0, 1, 0, '0, 1);
        checkOutput("stats.flush_stall", W'(stallCnt), W'(3));
        checkOutput("stats.flush_bubble", W'(bubbleCnt), W'(4));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
